// File: rtl/sort_ctrl_if.sv
// Load/drain stream bundle for sort_ctrl: valid/ready on both sides, out_last marks batch end.
interface sort_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_ctrl.sv
// Batch bubble sorter: load DEPTH signed bytes, sort one compare/cycle, drain ascending; in stalls in SORT/DRAIN, out holds under out_ready=0.
// Latency DEPTH*(DEPTH-1)/2 sort cycles; define SORT_EARLY_EXIT_EN to stop after the first swap-free pass.
module sort_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sort_ctrl_if.slave  bus,
    output logic        busy,
    output logic [7:0]  sort_cycles
);

    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [7:0] entry [DEPTH];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     cmp_idx;
    logic [IW-1:0]     pass_idx;
    logic              pass_swapped;

    logic              in_rdy;
    logic              out_vld;
    logic              out_lst;
    logic              in_fire;
    logic              out_fire;
    logic              load_done;
    logic [IW-1:0]     cmp_nxt;
    logic signed [7:0] cmp_lo;
    logic signed [7:0] cmp_hi;
    logic              do_swap;
    logic              pass_end;
    logic              sort_done;

    assign cmp_nxt   = cmp_idx + 1'b1;
    assign cmp_lo    = entry[cmp_idx];
    assign cmp_hi    = entry[cmp_nxt];
    assign do_swap   = (state == SORT) && (cmp_hi < cmp_lo);
    assign pass_end  = (cmp_idx == (LAST_PASS - pass_idx));

`ifdef SORT_EARLY_EXIT_EN
    // A pass that moved nothing proves the batch is already ordered.
    assign sort_done = pass_end && ((pass_idx == LAST_PASS) || !(pass_swapped || do_swap));
`else
    assign sort_done = pass_end && (pass_idx == LAST_PASS);
`endif

    assign in_fire   = (state == LOAD) && bus.in_valid;
    assign out_fire  = (state == DRAIN) && bus.out_ready;
    assign load_done = in_fire && (wr_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        out_lst   = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_rdy = 1'b1;
                if (load_done) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_vld = 1'b1;
                out_lst = (rd_idx == LAST_IDX);
                if (bus.out_ready && out_lst) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_last  = out_lst;
    // Entries are frozen during DRAIN, so a stalled output stays stable for free.
    assign bus.out_data  = entry[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry[k] <= 8'sh00;
            end
            wr_idx       <= '0;
            rd_idx       <= '0;
            cmp_idx      <= '0;
            pass_idx     <= '0;
            pass_swapped <= 1'b0;
            sort_cycles  <= 8'd0;
        end else begin
            if (in_fire) begin
                entry[wr_idx] <= $signed(bus.in_data);
                wr_idx        <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end

            if (load_done) begin
                sort_cycles  <= 8'd0;
                cmp_idx      <= '0;
                pass_idx     <= '0;
                pass_swapped <= 1'b0;
            end

            if (state == SORT) begin
                sort_cycles <= sort_cycles + 8'd1;
                if (do_swap) begin
                    entry[cmp_idx] <= cmp_hi;
                    entry[cmp_nxt] <= cmp_lo;
                end
                if (pass_end) begin
                    cmp_idx      <= '0;
                    pass_idx     <= pass_idx + 1'b1;
                    pass_swapped <= 1'b0;
                end else begin
                    cmp_idx      <= cmp_nxt;
                    pass_swapped <= pass_swapped | do_swap;
                end
            end

            if (out_fire) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
        end
    end

endmodule
